regfile_wr_arbiter: RTL
=======================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the register write-data width.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rstn, input, 1, synchronous active-low reset, sampled on rising clk.
REQ-004 The block SHALL have port req0_valid, input, 1, requester 0 (ALU writeback) has a write pending.
REQ-005 The block SHALL have port req0_addr, input, 5, requester 0 destination register index.
REQ-006 The block SHALL have port req0_data, input, DATA_W, requester 0 write data.
REQ-007 The block SHALL have port req0_ready, output, 1, requester 0 transfer accepted this cycle.
REQ-008 The block SHALL have ports req1_valid, req1_addr, req1_data and req1_ready (load writeback), with the same directions, widths and meanings as the req0 ports.
REQ-009 The block SHALL have port wr_stall, input, 1, register file cannot write this cycle.
REQ-010 The block SHALL have port wr_en, output, 32, registered one-hot word write-enable to the register file.
REQ-011 The block SHALL have port wr_addr, output, 5, registered index of the current write.
REQ-012 The block SHALL have port wr_data, output, DATA_W, registered data of the current write.
REQ-013 The block SHALL have port wr_count, output, 16, number of non-zero-index writes issued.

Function
REQ-014 Transfer on requester N SHALL occur in a cycle where reqN_valid and reqN_ready are both 1.
REQ-015 Arbitration: only one valid -> that requester granted; both valid -> the requester not granted last (last_grant register) is granted; none valid -> no grant.
REQ-016 reqN_ready SHALL be combinational: 1 iff requester N is granted and wr_stall is 0; at most one ready high per cycle.
REQ-017 reqN_ready SHALL not depend on reqN_data, and SHALL not be asserted for a requester whose valid is 0.
REQ-018 last_grant SHALL update only on a completed transfer, to the index of the transferring requester.
REQ-019 On a transfer, the next edge SHALL load wr_addr and wr_data from the winner and wr_en with the 5-to-32 one-hot decode of its addr (bit k high iff addr==k).
REQ-020 Index 0 (hardwired zero register): transfer SHALL still complete (ready=1), but wr_en SHALL load all zeros; wr_addr and wr_data load normally.
REQ-021 With wr_stall=0 and no transfer, the next edge SHALL clear wr_en to zero; wr_addr and wr_data hold.
REQ-022 With wr_stall=1, wr_en, wr_addr, wr_data, last_grant and wr_count SHALL hold their values, and both readys SHALL be 0.
REQ-023 Latency: request accepted in cycle T -> wr_en visible in cycle T+1; sustained throughput one write per cycle.
REQ-024 wr_count SHALL increment by 1 on each edge that loads a non-zero wr_en, and wrap from 0xFFFF to 0x0000.
REQ-025 A requester whose valid stays high while losing SHALL be granted no later than the next transfer (no starvation: strict alternation under continuous contention).
REQ-026 Same index from both requesters in one cycle SHALL be serialised by arbitration; no merging, no dropped write.

Reset
REQ-027 When rstn=0 at a clock edge: wr_en=0, wr_addr=0, wr_data=0, wr_count=0, last_grant=1 (so req0 wins first contention).
REQ-028 While rstn=0 both readys SHALL be 0 and no transfer SHALL occur; reset mid-stream discards the in-flight write without a wr_en pulse after reset.
REQ-029 First transfer after reset SHALL be possible in the first cycle rstn samples 1.

Verification
REQ-030 Single write: req0 valid, addr=5, data=0xDEADBEEF, stall=0 -> req0_ready=1 same cycle; next cycle wr_en=0x00000020, wr_data=0xDEADBEEF, wr_count=1; following cycle wr_en=0.
REQ-031 Contention: both valid continuously for 4 cycles after reset, addrs 1 (req0) and 2 (req1) -> grant order req0, req1, req0, req1; wr_en sequence 0x2,0x4,0x2,0x4; wr_count=4.
REQ-032 Stall: transfer to addr 31 then wr_stall=1 for 3 cycles with both valid -> wr_en holds 0x80000000, both readys 0, wr_count unchanged; release -> arbitration resumes with last_grant respected.
REQ-033 Zero register: req1 addr=0, data=0x1234 -> req1_ready=1, next cycle wr_en=0, wr_addr=0, wr_count unchanged.
REQ-034 Wrap and reset: preload via 65536 writes to addr 3 -> wr_count=0x0000; then assert rstn=0 in a cycle with a transfer -> next cycle all outputs 0, no wr_en pulse.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Two-requester register-file write arbiter (ALU vs load writeback), round-robin on contention.
// Latency: accept in T, registered one-hot wr_en in T+1; wr_stall holds all state and drops both readys.
module regfile_wr_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req0_valid,
  input  logic [4:0]        req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [4:0]        req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              wr_stall,
  output logic [31:0]       wr_en,
  output logic [4:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [15:0]       wr_count
);

  logic              last_grant_q, last_grant_d;
  logic [31:0]       wr_en_q, wr_en_d;
  logic [4:0]        wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [15:0]       wr_count_q, wr_count_d;

  logic              grant0, grant1;
  logic              xfer;
  logic              win_idx;
  logic [4:0]        win_addr;
  logic [DATA_W-1:0] win_data;
  logic [31:0]       win_dec;

  // On contention the requester that did not win last time goes next.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant_q);
    grant1 = req1_valid && (!req0_valid || !last_grant_q);
  end

  assign req0_ready = grant0 && !wr_stall && rstn;
  assign req1_ready = grant1 && !wr_stall && rstn;
  assign xfer       = req0_ready || req1_ready;

  always_comb begin
    win_idx  = req1_ready;
    win_addr = req1_ready ? req1_addr : req0_addr;
    win_data = req1_ready ? req1_data : req0_data;
  end

  // Register 0 is hardwired zero, so its decode never raises an enable.
  always_comb begin
    win_dec = '0;
    for (int k = 1; k < 32; k++) begin
      win_dec[k] = (win_addr == 5'(k));
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    wr_en_d      = wr_en_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_count_d   = wr_count_q;
    if (!wr_stall) begin
      if (xfer) begin
        last_grant_d = win_idx;
        wr_en_d      = win_dec;
        wr_addr_d    = win_addr;
        wr_data_d    = win_data;
        if (win_addr != 5'd0) begin
          wr_count_d = wr_count_q + 16'd1;
        end
      end else begin
        wr_en_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_grant_q <= 1'b1;
      wr_en_q      <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_count_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_count_q   <= wr_count_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_count = wr_count_q;

endmodule
